mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbiter between the pipelined RISC-V core's instruction-fetch port and load/store port for one single-ported, synchronous, word-wide unified memory holding both the .text and .data images. Each cycle it grants at most one requester. The load/store port has fixed priority, bounded by an anti-starvation counter. Read data returns with one-cycle latency, and the block range- and alignment-checks every request.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte-address width of both request ports
- DATA_WIDTH, 32, data width; one memory word
- MEM_DEPTH, 32'h4000, memory size in bytes; must be a power of two and a multiple of 4
- STARVE_LIMIT, 4, number of consecutive contested load/store grants after which fetch is forced

Ports:
- clock  in  1  single clock; all state updates on its rising edge
- reset_n  in  1  synchronous, active-low reset
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_req_addr  in  ADDR_WIDTH  fetch byte address
- if_flush  in  1  discard the fetch response due this cycle
- if_rsp_valid  out  1  fetch response
- if_rsp_data  out  DATA_WIDTH  instruction word
- if_rsp_err  out  1  fetch address misaligned or out of range
- dm_req_valid  in  1  load/store request
- dm_req_ready  out  1  load/store request accepted this cycle
- dm_req_addr  in  ADDR_WIDTH  load/store byte address
- dm_req_we  in  1  1 = store, 0 = load
- dm_req_wdata  in  DATA_WIDTH  store data, lane-aligned
- dm_req_wstrb  in  4  store byte enables
- dm_rsp_valid  out  1  load/store response
- dm_rsp_data  out  DATA_WIDTH  load word; 0 for stores and errors
- dm_rsp_err  out  1  load/store address misaligned or out of range
- mem_en  out  1  memory access enable
- mem_we  out  4  byte write enables; 0 on reads
- mem_addr  out  log2(MEM_DEPTH)-2  word index, i.e. byte address [log2(MEM_DEPTH)-1:2]
- mem_wdata  out  DATA_WIDTH  write data
- mem_rdata  in  DATA_WIDTH  read data; valid the cycle after mem_en

## Operation
- **Legal request:** addr[1:0] == 0 and addr < MEM_DEPTH. Anything else is an error request.
  - Error requests are granted normally.
  - mem_en stays 0 for them.
  - They receive a response with err = 1 and data = 0.
- **Arbitration** each cycle, outside reset:
  - force_if = (starve_cnt == STARVE_LIMIT).
  - dm_req_ready = !(force_if && if_req_valid).
  - if_req_ready = !dm_req_valid || force_if.
  - Both ready outputs are combinational. A port's request is granted when its valid and ready are both 1.
- **Starve counter** (starve_cnt, saturating, width clog2(STARVE_LIMIT+1)):
  - Increments when dm is granted while if_req_valid = 1.
  - Clears when fetch is granted, or when if_req_valid = 0.
  - Otherwise holds.
- **Memory drive:** mem_* are combinational from the granted request in the same cycle.
  - Fetch: mem_we = 0.
  - Load: mem_we = 0.
  - Store: mem_we = dm_req_wstrb, mem_wdata = dm_req_wdata.
  - Idle or error grant: mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- **Response registers:** one each per port. Each records grant, is-error, and is-load for the following cycle.
- **Responses:** no backpressure on responses; requesters must sink them.
- **Flush:** when if_flush = 1 in the fetch response cycle, if_rsp_valid is suppressed. The memory read still occurred.
- **Store with wstrb = 0:** legal. mem_en = 1, mem_we = 0, and a response is returned.

## Timing
- **Reset:** while reset_n = 0 at a rising edge, the following are cleared:
  - starve_cnt
  - both response registers
- **Outputs while reset_n = 0:** every output is 0, including both ready outputs and mem_en.
- **First cycle after reset:** normal arbitration.
- **Latency:** request granted in cycle N produces rsp_valid in cycle N+1.
  - rsp_data = mem_rdata for a legal load or fetch.
  - rsp_data = 0 otherwise.
  - Each port has at most one response per cycle.
  - Back-to-back grants to the same port give back-to-back responses.
- **Mid-operation reset:** reset asserted in cycle N+1 of a pending response suppresses that response. No response is emitted after reset deasserts.
- **Simultaneous request and response:** a request granted in cycle N+1 while the cycle-N response is presented is legal, giving full throughput.
- **Steady contention** (both valid every cycle, STARVE_LIMIT = L): the grant pattern repeats as L dm grants then 1 if grant.

## Test plan
- **Reset and first grant:** reset_n = 0 for 3 cycles with both valids high -> all outputs 0. Release reset -> dm granted in the first cycle, starve_cnt = 1.
- **Fetch latency:** preload word index 1 = 32'h00000297. Fetch at 0x4 alone -> mem_en = 1, mem_addr = 1. Next cycle if_rsp_valid = 1, data = 32'h00000297, err = 0.
- **Store then load:** store 0xDEADBEEF, wstrb 4'b0011, to 0x100. Then load 0x100 from a pre-zeroed word -> load returns 32'h0000BEEF. Both responses arrive exactly 1 cycle after their grants.
- **Starvation bound:** both ports valid continuously for 10 cycles, STARVE_LIMIT = 4 -> grants dm,dm,dm,dm,if,dm,dm,dm,dm,if.
- **Errors:** load at 0x102 -> dm_rsp_err = 1, data 0, mem_en = 0. Fetch at 0x4000 -> if_rsp_err = 1.
- **Flush and mid-response reset:** fetch granted, if_flush = 1 in the next cycle -> no if_rsp_valid. Separately, reset_n = 0 in a response cycle -> dm_rsp_valid = 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Request/response/memory bundle between the core ports, the arbiter and the unified memory.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 32'h4000
);
    localparam int unsigned MEM_AW = $clog2(MEM_DEPTH) - 2;

    logic                  if_req_valid;
    logic                  if_req_ready;
    logic [ADDR_WIDTH-1:0] if_req_addr;
    logic                  if_flush;
    logic                  if_rsp_valid;
    logic [DATA_WIDTH-1:0] if_rsp_data;
    logic                  if_rsp_err;

    logic                  dm_req_valid;
    logic                  dm_req_ready;
    logic [ADDR_WIDTH-1:0] dm_req_addr;
    logic                  dm_req_we;
    logic [DATA_WIDTH-1:0] dm_req_wdata;
    logic [3:0]            dm_req_wstrb;
    logic                  dm_rsp_valid;
    logic [DATA_WIDTH-1:0] dm_rsp_data;
    logic                  dm_rsp_err;

    logic                  mem_en;
    logic [3:0]            mem_we;
    logic [MEM_AW-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  if_req_valid, if_req_addr, if_flush,
        output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
        input  dm_req_valid, dm_req_addr, dm_req_we, dm_req_wdata, dm_req_wstrb,
        output dm_req_ready, dm_rsp_valid, dm_rsp_data, dm_rsp_err,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requester / memory side.
    modport master (
        output if_req_valid, if_req_addr, if_flush,
        input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
        output dm_req_valid, dm_req_addr, dm_req_we, dm_req_wdata, dm_req_wstrb,
        input  dm_req_ready, dm_rsp_valid, dm_rsp_data, dm_rsp_err,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch vs load/store arbiter for a single-ported unified memory with bounded fetch starvation.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MEM_DEPTH    = 32'h4000,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned MEM_BITS = $clog2(MEM_DEPTH);
    localparam int unsigned CNT_W    = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic valid;
        logic err;
        logic load;
    } rsp_t;

    logic [CNT_W-1:0] starve_q, starve_d;
    rsp_t             if_rsp_q, if_rsp_d;
    rsp_t             dm_rsp_q, dm_rsp_d;
    logic             force_if, if_gnt, dm_gnt, if_legal, dm_legal, if_vis, dm_vis;

    // Word aligned and inside the memory image.
    function automatic logic is_legal(input logic [ADDR_WIDTH-1:0] a);
        return (a[1:0] == 2'b00) && ((a >> MEM_BITS) == ADDR_WIDTH'(0));
    endfunction

    // Arbitration, starvation counter next state and memory drive.
    always_comb begin
        bus.if_req_ready = 1'b0;
        bus.dm_req_ready = 1'b0;
        bus.mem_en       = 1'b0;
        bus.mem_we       = 4'b0000;
        bus.mem_addr     = '0;
        bus.mem_wdata    = DATA_WIDTH'(0);
        starve_d         = starve_q;

        force_if = (starve_q == CNT_W'(STARVE_LIMIT));
        if_legal = is_legal(bus.if_req_addr);
        dm_legal = is_legal(bus.dm_req_addr);

        if (reset_n) begin
            bus.dm_req_ready = !(force_if && bus.if_req_valid);
            bus.if_req_ready = !bus.dm_req_valid || force_if;
        end
        if_gnt = bus.if_req_valid && bus.if_req_ready;
        dm_gnt = bus.dm_req_valid && bus.dm_req_ready;

        if (dm_gnt && dm_legal) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.dm_req_addr[MEM_BITS-1:2];
            if (bus.dm_req_we) begin
                bus.mem_we    = bus.dm_req_wstrb;
                bus.mem_wdata = bus.dm_req_wdata;
            end
        end else if (if_gnt && if_legal) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.if_req_addr[MEM_BITS-1:2];
        end

        if (if_gnt || !bus.if_req_valid) begin
            starve_d = '0;
        end else if (dm_gnt && !force_if) begin
            starve_d = starve_q + CNT_W'(1);
        end

        if_rsp_d.valid = if_gnt;
        if_rsp_d.err   = !if_legal;
        if_rsp_d.load  = 1'b1;
        dm_rsp_d.valid = dm_gnt;
        dm_rsp_d.err   = !dm_legal;
        dm_rsp_d.load  = !bus.dm_req_we;
    end

    // Response outputs: one cycle after grant, blanked by reset and fetch flush.
    always_comb begin
        if_vis           = reset_n && if_rsp_q.valid && !bus.if_flush;
        dm_vis           = reset_n && dm_rsp_q.valid;
        bus.if_rsp_valid = if_vis;
        bus.if_rsp_err   = if_vis && if_rsp_q.err;
        bus.if_rsp_data  = (if_vis && !if_rsp_q.err && if_rsp_q.load) ? bus.mem_rdata
                                                                      : DATA_WIDTH'(0);
        bus.dm_rsp_valid = dm_vis;
        bus.dm_rsp_err   = dm_vis && dm_rsp_q.err;
        bus.dm_rsp_data  = (dm_vis && !dm_rsp_q.err && dm_rsp_q.load) ? bus.mem_rdata
                                                                      : DATA_WIDTH'(0);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            starve_q <= '0;
            if_rsp_q <= '0;
            dm_rsp_q <= '0;
        end else begin
            starve_q <= starve_d;
            if_rsp_q <= if_rsp_d;
            dm_rsp_q <= dm_rsp_d;
        end
    end
endmodule
